// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 strip transmitter.
// Default timings assume a 40 MHz clock.
package ws2812_pkg;

    localparam int unsigned GRB_W         = 24;
    localparam int unsigned DEF_TBIT      = 50;
    localparam int unsigned DEF_T0H       = 16;
    localparam int unsigned DEF_T1H       = 32;
    localparam int unsigned DEF_RESET_CYC = 12000;
    // The slot that ends bit 8 is followed by the bit-7 slot (16 bits sent).
    localparam int unsigned PREFETCH_BIT  = 8;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        SEND,
        STALL,
        LATCH
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws2812_bit_slot.sv
// One WS2812 bit slot: TBIT cycles, high for T1H (bit 1) or T0H (bit 0) cycles.
// A start on the last slot cycle chains the next slot with no gap.
module ws2812_bit_slot
    import ws2812_pkg::*;
#(
    parameter int unsigned TBIT = DEF_TBIT,
    parameter int unsigned T0H  = DEF_T0H,
    parameter int unsigned T1H  = DEF_T1H
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic tx_bit,
    output logic dout,
    output logic slot_end
);

    localparam int unsigned   CW   = cnt_width(TBIT);
    localparam logic [CW-1:0] LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] HI0  = CW'(T0H);
    localparam logic [CW-1:0] HI1  = CW'(T1H);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          level;
    logic          running;

    assign cnt_next = cnt + 1'b1;
    assign slot_end = running && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            level   <= 1'b0;
            running <= 1'b0;
            dout    <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            level   <= tx_bit;
            running <= 1'b1;
            dout    <= 1'b1;
        end else if (slot_end) begin
            running <= 1'b0;
            dout    <= 1'b0;
        end else if (running) begin
            cnt  <= cnt_next;
            dout <= cnt_next < (level ? HI1 : HI0);
        end
    end

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 serial transmitter: fetches GRB words with a one-word prefetch,
// shifts them out MSB-first as bit slots and ends each frame with a latch period.
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS  = 100,
    parameter int unsigned TBIT      = DEF_TBIT,
    parameter int unsigned T0H       = DEF_T0H,
    parameter int unsigned T1H       = DEF_T1H,
    parameter int unsigned RESET_CYC = DEF_RESET_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [GRB_W-1:0] grb_in,
    input  logic             grb_valid,
    output logic             data_rd,
    output logic             dout,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned   PW       = cnt_width(NUM_LEDS);
    localparam int unsigned   LW       = cnt_width(RESET_CYC);
    localparam int unsigned   BW       = cnt_width(GRB_W);
    localparam logic [PW-1:0] LAST_PIX = PW'(NUM_LEDS - 1);
    localparam logic [LW-1:0] LAST_LAT = LW'(RESET_CYC - 1);
    localparam logic [BW-1:0] TOP_BIT  = BW'(GRB_W - 1);
    localparam logic [BW-1:0] PF_BIT   = BW'(PREFETCH_BIT);

    state_t           state;
    logic [GRB_W-1:0] shreg;
    logic [GRB_W-1:0] next_buf;
    logic [GRB_W-1:0] next_word;
    logic             next_full;
    logic             pending;
    logic             grb_valid_q;
    logic             post_rst;
    logic [BW-1:0]    bit_idx;
    logic [PW-1:0]    pix_cnt;
    logic [LW-1:0]    lat_cnt;
    logic             capture;
    logic             last_pix;
    logic             next_avail;
    logic             start;
    logic             tx_bit;
    logic             slot_end;

    // A word arriving on the very edge that ends bit 0 is used directly,
    // so it is never stranded behind a STALL that waits for another edge.
    always_comb begin
        capture    = pending && grb_valid && !grb_valid_q;
        last_pix   = (pix_cnt == LAST_PIX);
        next_avail = next_full || capture;
        next_word  = next_full ? next_buf : grb_in;
        start      = 1'b0;
        tx_bit     = 1'b0;
        case (state)
            FIRST, STALL: begin
                if (capture) begin
                    start  = 1'b1;
                    tx_bit = grb_in[GRB_W-1];
                end
            end
            SEND: begin
                if (slot_end) begin
                    if (bit_idx != '0) begin
                        start  = 1'b1;
                        tx_bit = shreg[GRB_W-2];
                    end else if (!last_pix && next_avail) begin
                        start  = 1'b1;
                        tx_bit = next_word[GRB_W-1];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LATCH;
            post_rst    <= 1'b1;
            shreg       <= '0;
            next_buf    <= '0;
            next_full   <= 1'b0;
            pending     <= 1'b0;
            grb_valid_q <= 1'b0;
            bit_idx     <= '0;
            pix_cnt     <= '0;
            lat_cnt     <= '0;
            data_rd     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            grb_valid_q <= grb_valid;
            data_rd     <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b1;
            if (capture) pending <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= enable;
                    if (enable) begin
                        data_rd <= 1'b1;
                        pending <= 1'b1;
                        state   <= FIRST;
                    end
                end
                FIRST: begin
                    if (capture) begin
                        shreg     <= grb_in;
                        bit_idx   <= TOP_BIT;
                        pix_cnt   <= '0;
                        next_full <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (capture) begin
                        next_buf  <= grb_in;
                        next_full <= 1'b1;
                    end
                    if (slot_end) begin
                        if (bit_idx != '0) begin
                            shreg   <= shreg << 1;
                            bit_idx <= bit_idx - 1'b1;
                            if (bit_idx == PF_BIT && !last_pix) begin
                                data_rd <= 1'b1;
                                pending <= 1'b1;
                            end
                        end else if (last_pix) begin
                            lat_cnt <= '0;
                            state   <= LATCH;
                        end else if (next_avail) begin
                            shreg     <= next_word;
                            next_full <= 1'b0;
                            bit_idx   <= TOP_BIT;
                            pix_cnt   <= pix_cnt + 1'b1;
                        end else begin
                            state <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (capture) begin
                        shreg   <= grb_in;
                        bit_idx <= TOP_BIT;
                        pix_cnt <= pix_cnt + 1'b1;
                        state   <= SEND;
                    end
                end
                LATCH: begin
                    if (lat_cnt == LAST_LAT) begin
                        busy       <= 1'b0;
                        frame_done <= !post_rst;
                        post_rst   <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ws2812_bit_slot #(
        .TBIT (TBIT),
        .T0H  (T0H),
        .T1H  (T1H)
    ) u_bit_slot (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tx_bit   (tx_bit),
        .dout     (dout),
        .slot_end (slot_end)
    );

endmodule

// File: tb/tb_ws2812_tx.sv
// Bench for ws2812_tx: a background pixel responder and trace recorder feed a
// waveform model built from pixel start times and bit-slot arithmetic.
module tb_ws2812_tx;

    localparam int N           = 3;
    localparam int TBIT        = 6;
    localparam int T0H         = 2;
    localparam int T1H         = 4;
    localparam int RESET_CYC   = 10;
    localparam int STALL_EXTRA = 60;
    localparam int MAXC        = 8000;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [23:0] grb_in;
    logic        grb_valid;
    logic        data_rd;
    logic        dout;
    logic        busy;
    logic        frame_done;

    logic        enable2;
    logic [23:0] grb_in2;
    logic        grb_valid2;
    logic        data_rd2;
    logic        dout2;
    logic        busy2;
    logic        frame_done2;

    logic        resp_valid;
    logic [23:0] resp_word;
    logic        spur;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          fd_count = 0;
    int          stall_at = -1;
    int          rd_cyc[$];
    int          rise_cyc[$];
    logic [23:0] word_log[$];
    logic [23:0] word_q[$];
    logic        tr_dout[0:MAXC-1];
    logic        tr_rd[0:MAXC-1];
    logic        tr_fd[0:MAXC-1];

    assign grb_valid = resp_valid | spur;
    assign grb_in    = spur ? ~resp_word : resp_word;

    ws2812_tx #(
        .NUM_LEDS  (N),
        .TBIT      (TBIT),
        .T0H       (T0H),
        .T1H       (T1H),
        .RESET_CYC (RESET_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .grb_in     (grb_in),
        .grb_valid  (grb_valid),
        .data_rd    (data_rd),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    ws2812_tx #(
        .NUM_LEDS  (1),
        .TBIT      (TBIT),
        .T0H       (T0H),
        .T1H       (T1H),
        .RESET_CYC (RESET_CYC)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable2),
        .grb_in     (grb_in2),
        .grb_valid  (grb_valid2),
        .data_rd    (data_rd2),
        .dout       (dout2),
        .busy       (busy2),
        .frame_done (frame_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rd(input int n);
        for (int k = 0; k < 3000 && rd_cyc.size() < n; k++) @(negedge clk);
        chk("rd_wait", rd_cyc.size(), n);
    endtask

    task automatic wait_fd(input int n);
        for (int k = 0; k < 4000 && fd_count < n; k++) @(negedge clk);
        chk("frame_done_wait", fd_count, n);
    endtask

    // Pixel i starts one cycle after its capture, but never before pixel i-1 ends.
    task automatic check_frame(input string tag, input int p0);
        int st[N];
        int en[N];
        int done, bad, first_bad, nrd, nfd, o;
        logic [23:0] w;
        logic e;
        if (rise_cyc.size() < p0 + N) begin
            chk({tag, "_responses"}, rise_cyc.size(), p0 + N);
            return;
        end
        for (int i = 0; i < N; i++) begin
            st[i] = rise_cyc[p0+i] + 1;
            if (i > 0 && en[i-1] > st[i]) st[i] = en[i-1];
            en[i] = st[i] + 24 * TBIT;
        end
        done = en[N-1] + RESET_CYC;
        bad = 0;
        first_bad = -1;
        for (int c = st[0] - 1; c < done && c < MAXC; c++) begin
            e = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (c >= st[i] && c < en[i]) begin
                    o = c - st[i];
                    w = word_log[p0+i];
                    e = (o % TBIT) < (w[23 - o / TBIT] ? T1H : T0H);
                end
            end
            if (tr_dout[c] !== e) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
        end
        chk({tag, "_wave_bad_cycles"}, bad, 0);
        if (first_bad >= 0) chk({tag, "_first_bad_cycle"}, first_bad, -1);
        nrd = 0;
        nfd = 0;
        for (int c = rd_cyc[p0]; c <= done && c < MAXC; c++) begin
            if (tr_rd[c] === 1'b1) nrd++;
            if (c >= st[0] && tr_fd[c] === 1'b1) nfd++;
        end
        chk({tag, "_rd_pulses"}, nrd, N);
        chk({tag, "_fd_pulses"}, nfd, 1);
        chk({tag, "_fd_at_end"}, tr_fd[done], 1);
        for (int i = 0; i < N - 1; i++)
            chk({tag, "_prefetch_cycle"}, rd_cyc[p0+i+1], st[i] + 16 * TBIT);
    endtask

    initial begin : responder
        int idx;
        logic [23:0] w;
        resp_valid = 1'b0;
        resp_word  = '0;
        forever begin
            @(negedge clk);
            if (data_rd === 1'b1) begin
                idx = rd_cyc.size();
                rd_cyc.push_back(cyc);
                w = (word_q.size() > 0) ? word_q.pop_front() : 24'($urandom);
                repeat ((idx == stall_at) ? 2 + STALL_EXTRA : 2) @(posedge clk);
                #1;
                resp_word  = w;
                resp_valid = 1'b1;
                rise_cyc.push_back(cyc);
                word_log.push_back(w);
                repeat (2) @(posedge clk);
                #1 resp_valid = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (cyc < MAXC) begin
                tr_dout[cyc] = dout;
                tr_rd[cyc]   = data_rd;
                tr_fd[cyc]   = frame_done;
            end
            if (frame_done === 1'b1) fd_count++;
        end
    end

    initial begin : main
        int c0, bad, fbad, nrd, nfd, fdpos, o;
        logic [23:0] w2;
        logic e;
        rst        = 1'b1;
        enable     = 1'b0;
        spur       = 1'b0;
        enable2    = 1'b0;
        grb_valid2 = 1'b0;
        grb_in2    = '0;
        repeat (3) @(negedge clk);
        chk("reset_dout", dout, 0);
        chk("reset_data_rd", data_rd, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_done", frame_done, 0);

        @(posedge clk);
        #1 rst = 1'b0;
        repeat (RESET_CYC + 4) @(negedge clk);
        chk("por_no_frame_done", fd_count, 0);
        chk("por_no_request", rd_cyc.size(), 0);
        chk("por_idle_busy", busy, 0);

        @(posedge clk);
        #1 spur = 1'b1;
        repeat (2) @(posedge clk);
        #1 spur = 1'b0;
        repeat (4) @(negedge clk);
        chk("spur_idle_busy", busy, 0);
        chk("spur_idle_no_rd", rd_cyc.size(), 0);

        word_q.push_back(24'hFF0000);
        word_q.push_back(24'h000000);
        word_q.push_back(24'hA5A5A5);
        for (int i = 0; i < N; i++) word_q.push_back(24'($urandom));
        stall_at = N + 2;
        enable = 1'b1;
        wait_fd(1);
        check_frame("frame_basic", 0);

        wait_rd(N + 1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1 spur = 1'b1;
        repeat (2) @(posedge clk);
        #1 spur = 1'b0;
        wait_fd(2);
        check_frame("frame_stall_spur", N);

        wait_rd(2 * N + 2);
        repeat (60) @(negedge clk);
        enable = 1'b0;
        wait_fd(3);
        check_frame("frame_enable_drop", 2 * N);
        repeat (20) @(negedge clk);
        chk("drop_idle_busy", busy, 0);
        chk("drop_no_new_rd", rd_cyc.size(), 3 * N);
        chk("drop_fd_count", fd_count, 3);

        enable = 1'b1;
        wait_rd(3 * N + 1);
        for (int k = 0; k < 20 && dout !== 1'b1; k++) @(negedge clk);
        chk("rst_pre_dout", dout, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_dout", dout, 0);
        chk("rst_async_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        c0 = cyc;
        bad = 0;
        fbad = 0;
        for (int i = 0; i < RESET_CYC; i++) begin
            @(negedge clk);
            if (dout !== 1'b0) bad++;
            if (frame_done !== 1'b0) fbad++;
        end
        chk("rst_latch_dout_high", bad, 0);
        chk("rst_latch_frame_done", fbad, 0);
        wait_rd(3 * N + 2);
        enable = 1'b0;
        chk("rst_restart_cycle", rd_cyc[3*N+1], c0 + RESET_CYC + 1);
        wait_fd(4);
        check_frame("frame_after_rst", 3 * N + 1);

        enable2 = 1'b1;
        for (int k = 0; k < 40 && data_rd2 !== 1'b1; k++) @(negedge clk);
        chk("n1_first_rd", data_rd2, 1);
        w2 = 24'($urandom);
        bad = 0;
        nrd = 0;
        nfd = 0;
        fdpos = -1;
        for (int j = 1; j <= 3 + 24 * TBIT + RESET_CYC + 3; j++) begin
            @(posedge clk);
            #1;
            enable2    = 1'b0;
            grb_in2    = w2;
            grb_valid2 = (j == 2 || j == 3);
            @(negedge clk);
            o = j - 3;
            if (o >= 0 && o < 24 * TBIT) e = (o % TBIT) < (w2[23 - o / TBIT] ? T1H : T0H);
            else e = 1'b0;
            if (dout2 !== e) bad++;
            if (data_rd2 === 1'b1) nrd++;
            if (frame_done2 === 1'b1) begin
                nfd++;
                fdpos = j;
            end
        end
        chk("n1_wave_bad_cycles", bad, 0);
        chk("n1_no_prefetch", nrd, 0);
        chk("n1_fd_pulses", nfd, 1);
        chk("n1_fd_cycle", fdpos, 3 + 24 * TBIT + RESET_CYC);
        chk("n1_idle_busy", busy2, 0);

        bad = 0;
        for (int c = 1; c < cyc && c < MAXC; c++)
            if (tr_rd[c] === 1'b1 && tr_rd[c-1] === 1'b1) bad++;
        chk("rd_back_to_back", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
